axis_interface: RTL and testbench

- AXI-Stream point-to-point register slice (skid buffer) with DATA_WIDTH payload plus tlast/tuser sideband.
- Fully registers both the forward path (tdata/tvalid/tlast/tuser) and the backward path (tready) between an upstream producer and a downstream consumer.
- Sits between stream blocks such as raw-sample sources and the COBS encoder to break timing paths without losing throughput.
- Also provides a count of output packets.

---
 rtl/axis_interface.sv | 145 ++++++++++++++
 tb/tb_axis_interface.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_interface.sv
// ============================================================================
// Module   : axis_interface
// Summary  : AXI-Stream register slice (skid buffer) with a tlast packet
//            counter. Optional checker enabled by the
//            AXIS_INTERFACE_PROTOCOL_CHECK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_interface #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic                   s_tlast,
    input  logic [USER_WIDTH-1:0]  s_tuser,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic [USER_WIDTH-1:0]  m_tuser,
    output logic [COUNT_WIDTH-1:0] packet_count
`ifdef AXIS_INTERFACE_PROTOCOL_CHECK_EN
    ,
    output logic                   protocol_error
`endif
);

    localparam int ENTRY_W = DATA_WIDTH + 1 + USER_WIDTH;

    logic [ENTRY_W-1:0]     r_out_entry;
    logic                   r_out_valid;
    logic [ENTRY_W-1:0]     r_skid_entry;
    logic                   r_skid_valid;
    logic                   r_s_ready;
    logic [COUNT_WIDTH-1:0] r_packet_count;

    logic [ENTRY_W-1:0]     w_s_entry;
    logic                   w_accept;
    logic                   w_out_free;
    logic [ENTRY_W-1:0]     w_out_entry_nxt;
    logic                   w_out_valid_nxt;
    logic [ENTRY_W-1:0]     w_skid_entry_nxt;
    logic                   w_skid_valid_nxt;

    assign w_s_entry  = {s_tdata, s_tlast, s_tuser};
    assign w_accept   = s_tvalid && r_s_ready;
    assign w_out_free = !r_out_valid || m_tready;

    // OUT refills from SKID first so beats leave in acceptance order.
    always_comb begin
        w_out_entry_nxt  = r_out_entry;
        w_out_valid_nxt  = r_out_valid;
        w_skid_entry_nxt = r_skid_entry;
        w_skid_valid_nxt = r_skid_valid;
        if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_entry_nxt  = r_skid_entry;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = w_accept;
                if (w_accept) begin
                    w_skid_entry_nxt = w_s_entry;
                end
            end else begin
                w_out_valid_nxt = w_accept;
                if (w_accept) begin
                    w_out_entry_nxt = w_s_entry;
                end
            end
        end else if (w_accept) begin
            w_skid_entry_nxt = w_s_entry;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_entry    <= '0;
            r_out_valid    <= 1'b0;
            r_skid_entry   <= '0;
            r_skid_valid   <= 1'b0;
            r_s_ready      <= 1'b0;
            r_packet_count <= '0;
        end else begin
            r_out_entry  <= w_out_entry_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid_entry <= w_skid_entry_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            // Ready derives only from SKID occupancy, never from m_tready.
            r_s_ready    <= !w_skid_valid_nxt;
            if (r_out_valid && m_tready && m_tlast) begin
                r_packet_count <= r_packet_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign s_tready     = r_s_ready;
    assign m_tvalid     = r_out_valid;
    assign m_tdata      = r_out_entry[ENTRY_W-1 -: DATA_WIDTH];
    assign m_tlast      = r_out_entry[USER_WIDTH];
    assign m_tuser      = r_out_entry[USER_WIDTH-1:0];
    assign packet_count = r_packet_count;

`ifdef AXIS_INTERFACE_PROTOCOL_CHECK_EN
    logic               r_prev_stall;
    logic [ENTRY_W-1:0] r_prev_entry;
    logic               r_protocol_error;
    logic               w_violation;

    // A stalled beat must stay valid and unchanged until it is accepted.
    assign w_violation = r_prev_stall && (!s_tvalid || (w_s_entry != r_prev_entry));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_stall     <= 1'b0;
            r_prev_entry     <= '0;
            r_protocol_error <= 1'b0;
        end else begin
            r_prev_stall <= s_tvalid && !r_s_ready;
            r_prev_entry <= w_s_entry;
            if (w_violation) begin
                r_protocol_error <= 1'b1;
            end
        end
    end

    assign protocol_error = r_protocol_error;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_violation) begin
            $error("axis_interface: stalled s-side beat dropped or changed");
        end
    end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_interface.sv
// ============================================================================
// Module   : tb_axis_interface
// Summary  : Scoreboard bench for axis_interface with directed stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_interface;

    localparam int DW = 8;
    localparam int UW = 1;
    localparam int CW = 16;
    localparam int EW = DW + 1 + UW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [UW-1:0] m_tuser;
    logic [CW-1:0] packet_count;
`ifdef AXIS_INTERFACE_PROTOCOL_CHECK_EN
    logic          protocol_error;
`endif

    axis_interface #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser),
        .packet_count(packet_count)
`ifdef AXIS_INTERFACE_PROTOCOL_CHECK_EN
        , .protocol_error(protocol_error)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ready_mode = 0;        // 0: ready high, 1: ready low, 2: random
    logic [EW-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Downstream ready is updated shortly after each edge, after the stimulus.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'b0;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {22'd0, m_tdata, m_tlast, m_tuser}, 32'hFFFF_FFFF);
            end else begin
                chk("beat", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l, input logic [UW-1:0] u);
        int guard = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        s_tuser  = u;
        while (!s_tready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            chk("send_timeout", 32'(guard), 32'd0);
        end else begin
            exp_q.push_back({d, l, u});
            tick();
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        s_tvalid = 1'b0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int t0;
        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tuser  = '0;
        m_tready = 1'b1;

        // Reset then idle
        tick();
        tick();
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_s_tready", 32'(s_tready), 32'd1);
        chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("idle_count", 32'(packet_count), 32'd0);

        // Continuous stream at full rate
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            send(8'h45, 1'b0, 1'b0);
            chk("stream_m_tvalid", 32'(m_tvalid), 32'd1);
            chk("stream_m_tdata", 32'(m_tdata), 32'h45);
        end
        chk("stream_cycles", 32'(cyc - t0), 32'd6);
        wait_drain();
        chk("stream_idle_m_tvalid", 32'(m_tvalid), 32'd0);

        // Stall: two beats accepted, third held off
        ready_mode = 1;
        tick();
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        chk("stall_s_tready", 32'(s_tready), 32'd0);
        s_tvalid = 1'b1;
        s_tdata  = 8'h03;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_m_tdata_hold", 32'(m_tdata), 32'h01);
            chk("stall_s_tready_hold", 32'(s_tready), 32'd0);
        end
        ready_mode = 0;
        tick();
        chk("release_m_tdata", 32'(m_tdata), 32'h02);
        chk("release_s_tready", 32'(s_tready), 32'd1);
        exp_q.push_back({8'h03, 1'b0, 1'b0});
        tick();
        s_tvalid = 1'b0;
        chk("release_m_tdata3", 32'(m_tdata), 32'h03);
        chk("release_m_tvalid3", 32'(m_tvalid), 32'd1);
        tick();
        chk("release_empty", 32'(m_tvalid), 32'd0);
        chk("count_no_last", 32'(packet_count), 32'd0);

        // Three 4-beat packets under random back-pressure
        ready_mode = 2;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                send(8'(8'h10 + p * 4 + b), (b == 3), 1'(p));
            end
        end
        ready_mode = 0;
        wait_drain();
        chk("packet_count", 32'(packet_count), 32'd3);

        // Reset while SKID is full
        ready_mode = 1;
        tick();
        send(8'hA1, 1'b1, 1'b0);
        send(8'hA2, 1'b1, 1'b1);
        s_tvalid = 1'b1;
        s_tdata  = 8'hA3;
        tick();
        chk("skid_full_s_tready", 32'(s_tready), 32'd0);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        exp_q.delete();
        tick();
        chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_s_tready", 32'(s_tready), 32'd0);
        chk("midrst_count", 32'(packet_count), 32'd0);
        rst        = 1'b0;
        ready_mode = 0;
        tick();
        chk("postrst_s_tready", 32'(s_tready), 32'd1);
        send(8'h5A, 1'b1, 1'b1);
        chk("postrst_m_tdata", 32'(m_tdata), 32'h5A);
        wait_drain();
        chk("postrst_count", 32'(packet_count), 32'd1);

`ifdef AXIS_INTERFACE_PROTOCOL_CHECK_EN
        chk("perr_clean", 32'(protocol_error), 32'd0);
        ready_mode = 1;
        tick();
        send(8'h0E, 1'b0, 1'b0);
        send(8'h0F, 1'b0, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 8'h10;
        tick();
        chk("perr_stalled_ok", 32'(protocol_error), 32'd0);
        s_tdata = 8'h11;
        tick();
        chk("perr_set", 32'(protocol_error), 32'd1);
        s_tvalid = 1'b0;
        tick();
        tick();
        chk("perr_sticky", 32'(protocol_error), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk("perr_cleared", 32'(protocol_error), 32'd0);
        rst        = 1'b0;
        ready_mode = 0;
        tick();
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
